ret_stack_ctrl: RTL and testbench

- Return-address stack controller that consumes the push/pop call-stack strobes produced by the jump decoder and supplies predicted return targets to the fetch redirect logic.
- Keeps a circular stack with speculative checkpoints. Branch mispredicts restore the stack state; a flush clears it.
- One instance per hardware thread, placed between the decode jump-classification stage and the fetch steering unit.

---
 rtl/ret_stack_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ret_stack_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ret_stack_ctrl.sv
// Return-address stack controller.
// Circular call stack fed by decode push/pop strobes. Speculative checkpoints
// let a mispredict roll the stack back, and a flush empties it.
module ret_stack_ctrl #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned IP_WIDTH = 48,
   parameter int unsigned NCKPT    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       dec_valid,
   output logic                       dec_ready,
   input  logic                       dec_push,
   input  logic                       dec_pop,
   input  logic [IP_WIDTH-1:0]        dec_ret_ip,
   input  logic                       ckpt_alloc,
   input  logic [$clog2(NCKPT)-1:0]   ckpt_id,
   input  logic                       restore_valid,
   input  logic [$clog2(NCKPT)-1:0]   restore_id,
   input  logic                       flush,
   output logic                       pred_valid,
   output logic [IP_WIDTH-1:0]        pred_ip,
   output logic [$clog2(DEPTH):0]     depth_cnt,
   output logic                       overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ID_W  = $clog2(NCKPT);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } state_t;

   // Snapshot of the stack pointer state plus the top value it guards.
   typedef struct packed {
      logic [PTR_W-1:0]    tos;
      logic [CNT_W-1:0]    cnt;
      logic [IP_WIDTH-1:0] top;
   } ckpt_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_dec_ready;
   logic [PTR_W-1:0]    r_tos;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_pred_valid;
   logic [IP_WIDTH-1:0] r_pred_ip;
   logic                r_overflow;

   logic [IP_WIDTH-1:0] r_entry [DEPTH];
   ckpt_t               r_ckpt  [NCKPT];

   logic                w_recover;
   logic                w_accept;
   logic [IP_WIDTH-1:0] w_top;
   logic [PTR_W-1:0]    w_tos_inc;
   logic [PTR_W-1:0]    w_tos_dec;
   ckpt_t               w_rst_ckpt;
   ckpt_t               w_new_ckpt;

   logic [PTR_W-1:0]    w_tos_nxt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_pv_nxt;
   logic [IP_WIDTH-1:0] w_pip_nxt;
   logic                w_ovf_nxt;
   logic                w_wr_en;
   logic [PTR_W-1:0]    w_wr_addr;
   logic [IP_WIDTH-1:0] w_wr_data;
   logic                w_ck_wr;

   // Restore and flush both steal the cycle from decode.
   assign w_recover  = restore_valid | flush;
   assign w_accept   = dec_valid & r_dec_ready & ~w_recover;
   assign w_top      = r_entry[r_tos];
   assign w_tos_inc  = r_tos + PTR_W'(1);
   assign w_tos_dec  = r_tos - PTR_W'(1);
   assign w_rst_ckpt = r_ckpt[restore_id];

   assign w_new_ckpt.tos = r_tos;
   assign w_new_ckpt.cnt = r_cnt;
   assign w_new_ckpt.top = w_top;

   assign dec_ready  = r_dec_ready;
   assign pred_valid = r_pred_valid;
   assign pred_ip    = r_pred_ip;
   assign depth_cnt  = r_cnt;
   assign overflow   = r_overflow;

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state: any restore/flush holds RECOVER for one more cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:     if (w_recover) w_state_nxt = ST_RECOVER;
         ST_RECOVER: w_state_nxt = w_recover ? ST_RECOVER : ST_RUN;
         default:    w_state_nxt = ST_RUN;
      endcase
   end

   // Next stack state, prediction and storage writes, by priority restore > flush > decode.
   always_comb begin
      w_tos_nxt = r_tos;
      w_cnt_nxt = r_cnt;
      w_pv_nxt  = 1'b0;
      w_pip_nxt = r_pred_ip;
      w_ovf_nxt = 1'b0;
      w_wr_en   = 1'b0;
      w_wr_addr = r_tos;
      w_wr_data = dec_ret_ip;
      w_ck_wr   = 1'b0;
      if (restore_valid) begin
         // Repair the top entry in case a speculative push overwrote it.
         w_tos_nxt = w_rst_ckpt.tos;
         w_cnt_nxt = w_rst_ckpt.cnt;
         w_wr_en   = 1'b1;
         w_wr_addr = w_rst_ckpt.tos;
         w_wr_data = w_rst_ckpt.top;
      end else if (flush) begin
         w_tos_nxt = '0;
         w_cnt_nxt = '0;
      end else if (w_accept) begin
         w_ck_wr = ckpt_alloc;
         if (dec_push && !dec_pop) begin
            w_tos_nxt = w_tos_inc;
            w_wr_en   = 1'b1;
            w_wr_addr = w_tos_inc;
            if (r_cnt == FULL_CNT) begin
               w_ovf_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end else if (dec_pop && !dec_push) begin
            // Empty pop is an underflow: fetch falls back to the BTB.
            if (r_cnt != '0) begin
               w_pv_nxt  = 1'b1;
               w_pip_nxt = w_top;
               w_tos_nxt = w_tos_dec;
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end else if (dec_push && dec_pop) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_tos;
            if (r_cnt != '0) begin
               w_pv_nxt  = 1'b1;
               w_pip_nxt = w_top;
            end else begin
               w_cnt_nxt = CNT_W'(1);
            end
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dec_ready  <= 1'b0;
         r_tos        <= '0;
         r_cnt        <= '0;
         r_pred_valid <= 1'b0;
         r_pred_ip    <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_dec_ready  <= (w_state_nxt == ST_RUN);
         r_tos        <= w_tos_nxt;
         r_cnt        <= w_cnt_nxt;
         r_pred_valid <= w_pv_nxt;
         r_pred_ip    <= w_pip_nxt;
         r_overflow   <= w_ovf_nxt;
      end
   end

   // Stack entry storage; contents are meaningless while the count is zero.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_entry[w_wr_addr] <= w_wr_data;
      end
   end

   // Checkpoint slots capture the pre-update state of the accepted op.
   always_ff @(posedge clk) begin
      if (w_ck_wr) begin
         r_ckpt[ID_W'(ckpt_id)] <= w_new_ckpt;
      end
   end

endmodule

// File: tb/tb_ret_stack_ctrl.sv
// Testbench for ret_stack_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural stack model.
module tb_ret_stack_ctrl;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned IPW   = 48;
   localparam int unsigned NCK   = 4;
   localparam int unsigned IDW   = $clog2(NCK);
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           dec_valid, dec_ready, dec_push, dec_pop;
   logic [IPW-1:0] dec_ret_ip;
   logic           ckpt_alloc;
   logic [IDW-1:0] ckpt_id;
   logic           restore_valid;
   logic [IDW-1:0] restore_id;
   logic           flush;
   logic           pred_valid;
   logic [IPW-1:0] pred_ip;
   logic [CW-1:0]  depth_cnt;
   logic           overflow;

   int tests = 0;
   int fails = 0;

   // Behavioural model state.
   logic [IPW-1:0] m_mem [DEPTH];
   int             m_tos, m_cnt;
   bit             m_rdy, m_pv, m_ovf;
   logic [IPW-1:0] m_pip;
   int             ck_tos [NCK];
   int             ck_cnt [NCK];
   logic [IPW-1:0] ck_top [NCK];
   bit             ck_written [NCK];

   ret_stack_ctrl #(.DEPTH(DEPTH), .IP_WIDTH(IPW), .NCKPT(NCK)) dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_push(dec_push), .dec_pop(dec_pop), .dec_ret_ip(dec_ret_ip),
      .ckpt_alloc(ckpt_alloc), .ckpt_id(ckpt_id),
      .restore_valid(restore_valid), .restore_id(restore_id),
      .flush(flush),
      .pred_valid(pred_valid), .pred_ip(pred_ip),
      .depth_cnt(depth_cnt), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_tos = 0; m_cnt = 0; m_rdy = 1'b0; m_pv = 1'b0; m_ovf = 1'b0; m_pip = '0;
      for (int i = 0; i < NCK; i++) ck_written[i] = 1'b0;
   endtask

   // Apply this cycle's inputs to the model: what the outputs must be after the edge.
   task automatic m_update();
      bit acc;
      int rid, aid;
      acc   = dec_valid && m_rdy && !restore_valid && !flush;
      rid   = int'(restore_id);
      aid   = int'(ckpt_id);
      m_pv  = 1'b0;
      m_ovf = 1'b0;
      if (restore_valid) begin
         m_tos = ck_tos[rid];
         m_cnt = ck_cnt[rid];
         m_mem[m_tos] = ck_top[rid];
      end else if (flush) begin
         m_tos = 0;
         m_cnt = 0;
      end else if (acc) begin
         if (ckpt_alloc) begin
            ck_tos[aid] = m_tos; ck_cnt[aid] = m_cnt; ck_top[aid] = m_mem[m_tos];
            ck_written[aid] = 1'b1;
         end
         if (dec_push && !dec_pop) begin
            m_ovf = (m_cnt == DEPTH);
            m_tos = (m_tos + 1) % DEPTH;
            m_mem[m_tos] = dec_ret_ip;
            if (m_cnt < DEPTH) m_cnt++;
         end else if (dec_pop && !dec_push) begin
            if (m_cnt > 0) begin
               m_pip = m_mem[m_tos]; m_pv = 1'b1;
               m_tos = (m_tos + DEPTH - 1) % DEPTH;
               m_cnt--;
            end
         end else if (dec_push && dec_pop) begin
            if (m_cnt > 0) begin
               m_pip = m_mem[m_tos]; m_pv = 1'b1;
            end else begin
               m_cnt = 1;
            end
            m_mem[m_tos] = dec_ret_ip;
         end
      end
      m_rdy = !(restore_valid || flush);
   endtask

   task automatic compare_all();
      chk("dec_ready", 64'(dec_ready), 64'(m_rdy));
      chk("depth_cnt", 64'(depth_cnt), 64'(m_cnt));
      chk("pred_valid", 64'(pred_valid), 64'(m_pv));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (m_pv) chk("pred_ip", 64'(pred_ip), 64'(m_pip));
   endtask

   task automatic step();
      m_update();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive(input bit v, input bit pu, input bit po, input logic [IPW-1:0] ip,
                        input bit al, input int aid, input bit rv, input int rid, input bit fl);
      dec_valid = v; dec_push = pu; dec_pop = po; dec_ret_ip = ip;
      ckpt_alloc = al; ckpt_id = IDW'(aid);
      restore_valid = rv; restore_id = IDW'(rid); flush = fl;
      step();
   endtask

   task automatic idle();        drive(0, 0, 0, '0, 0, 0, 0, 0, 0); endtask
   task automatic push(input logic [IPW-1:0] ip); drive(1, 1, 0, ip, 0, 0, 0, 0, 0); endtask
   task automatic pop();         drive(1, 0, 1, '0, 0, 0, 0, 0, 0); endtask

   initial begin
      logic [IPW-1:0] a;
      logic [IPW-1:0] rip;
      int r, slot;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int i = 0; i < NCK; i++) begin ck_tos[i] = 0; ck_cnt[i] = 0; ck_top[i] = '0; end
      rst = 1'b0;
      dec_valid = 0; dec_push = 0; dec_pop = 0; dec_ret_ip = '0;
      ckpt_alloc = 0; ckpt_id = '0; restore_valid = 0; restore_id = '0; flush = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", 64'(dec_ready), 64'd0);
      chk("reset_depth", 64'(depth_cnt), 64'd0);
      chk("reset_pv", 64'(pred_valid), 64'd0);
      chk("reset_pip", 64'(pred_ip), 64'd0);
      @(negedge clk) rst = 1'b1;
      idle();
      chk("ready_after_reset", 64'(dec_ready), 64'd1);

      // Pop on empty: underflow, nothing predicted.
      pop();
      chk("empty_pop_pv", 64'(pred_valid), 64'd0);
      chk("empty_pop_depth", 64'(depth_cnt), 64'd0);

      // Basic LIFO order.
      push(48'h1000); push(48'h2000); push(48'h3000);
      chk("depth3", 64'(depth_cnt), 64'd3);
      pop();
      chk("pop1_pv", 64'(pred_valid), 64'd1);
      chk("pop1_ip", 64'(pred_ip), 64'h3000);
      chk("model_pin_pop1", 64'(m_pip), 64'h3000);
      pop();
      chk("pop2_ip", 64'(pred_ip), 64'h2000);
      pop();
      chk("pop3_ip", 64'(pred_ip), 64'h1000);
      chk("depth0", 64'(depth_cnt), 64'd0);

      // Overflow: 17 pushes into a 16-deep stack.
      for (int i = 0; i <= 16; i++) begin
         a = 48'hA000 + 48'(i);
         push(a);
      end
      chk("ovf_pulse", 64'(overflow), 64'd1);
      chk("ovf_depth", 64'(depth_cnt), 64'd16);
      idle();
      chk("ovf_one_cycle", 64'(overflow), 64'd0);
      for (int i = 16; i >= 1; i--) begin
         pop();
         chk("ovf_pop_ip", 64'(pred_ip), 64'hA000 + 64'(i));
      end
      pop();
      chk("ovf_17th_pop_pv", 64'(pred_valid), 64'd0);

      // Checkpoint/restore repairs a speculative overwrite.
      push(48'h100);
      drive(1, 0, 1, '0, 1, 2, 0, 0, 0);
      chk("ck_pop_ip", 64'(pred_ip), 64'h100);
      push(48'h500); push(48'h600);
      drive(0, 0, 0, '0, 0, 0, 1, 2, 0);
      chk("restore_ready", 64'(dec_ready), 64'd0);
      chk("restore_depth", 64'(depth_cnt), 64'd1);
      idle();
      chk("restore_ready_back", 64'(dec_ready), 64'd1);
      pop();
      chk("restore_pop_ip", 64'(pred_ip), 64'h100);
      chk("model_pin_restore", 64'(m_pip), 64'h100);

      // Restore beats flush beats push, all in one cycle.
      push(48'h700);
      drive(1, 1, 0, 48'h800, 1, 1, 0, 0, 0);
      push(48'h900);
      drive(1, 1, 0, 48'h999, 0, 0, 1, 1, 1);
      chk("prio_ready", 64'(dec_ready), 64'd0);
      chk("prio_depth", 64'(depth_cnt), 64'd1);
      idle();
      chk("prio_one_recover", 64'(dec_ready), 64'd1);
      pop();
      chk("prio_pop_ip", 64'(pred_ip), 64'h700);

      // Asynchronous reset in the middle of RECOVER.
      push(48'hB0);
      drive(0, 0, 0, '0, 0, 0, 1, 1, 0);
      chk("pre_rst_recover", 64'(dec_ready), 64'd0);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_ready", 64'(dec_ready), 64'd0);
      chk("async_rst_depth", 64'(depth_cnt), 64'd0);
      chk("async_rst_pv", 64'(pred_valid), 64'd0);
      chk("async_rst_ovf", 64'(overflow), 64'd0);
      m_reset();
      dec_valid = 0; restore_valid = 0; flush = 0;
      @(negedge clk) rst = 1'b1;
      idle();
      chk("post_rst_ready", 64'(dec_ready), 64'd1);
      chk("post_rst_depth", 64'(depth_cnt), 64'd0);

      // Random traffic with alternating push-heavy and pop-heavy phases.
      for (int i = 0; i < 3000; i++) begin
         r   = int'($urandom_range(0, 99));
         rip = {16'($urandom), $urandom};
         dec_valid     = ($urandom_range(0, 99) < 85);
         ckpt_alloc    = ($urandom_range(0, 3) == 0);
         ckpt_id       = IDW'($urandom_range(0, NCK - 1));
         dec_ret_ip    = rip;
         restore_valid = 1'b0;
         restore_id    = '0;
         flush         = ($urandom_range(0, 99) < 2);
         slot          = int'($urandom_range(0, NCK - 1));
         if (r < 5 && ck_written[slot]) begin
            restore_valid = 1'b1;
            restore_id    = IDW'(slot);
         end
         r = int'($urandom_range(0, 99));
         if (((i / 150) % 2) == 0) begin
            dec_push = (r < 70) || (r >= 90);
            dec_pop  = (r >= 70);
         end else begin
            dec_push = (r < 25) || (r >= 90);
            dec_pop  = (r >= 25);
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
